// File: rtl/ov7670_cfg_pkg.sv
// rtl/ov7670_cfg_pkg.sv - shared constants and state encoding for the OV7670 config path
//
// Purpose: marker constants shared by the config ROM and the sequencer,
// the 3-bit FSM state encoding, and the default delay length.
// Ports: none (package).
package ov7670_cfg_pkg;

    localparam logic [15:0] CFG_DELAY   = 16'hFFF0;
    localparam logic [15:0] CFG_END     = 16'hFFFF;
    localparam logic [7:0]  CFG_MARK_HI = 8'hFF;

    localparam int DEFAULT_DELAY_MS = 10;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_WAIT_SCCB = 3'd4;
    localparam logic [2:0] ST_DELAY     = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_FETCH     = ST_FETCH,
        S_DECODE    = ST_DECODE,
        S_SEND      = ST_SEND,
        S_WAIT_SCCB = ST_WAIT_SCCB,
        S_DELAY     = ST_DELAY,
        S_DONE      = ST_DONE
    } cfg_state_e;

endpackage

// File: rtl/ov7670_config_seq.sv
// rtl/ov7670_config_seq.sv - walks the OV7670 config ROM and issues SCCB register writes
//
// Purpose: reads 16-bit {reg_addr, reg_data} entries from a registered ROM
// starting at address 0, issues each normal entry to the SCCB write master,
// inserts a DELAY_MS pause for each 0xFFF0 entry and stops on any other
// 0xFFxx entry or after address 255.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             single-cycle begin/restart request (honoured in IDLE/DONE)
//   rom_addr/rom_dout config ROM address out, data in (1-cycle read latency)
//   sccb_addr/data    register address/data held for the SCCB master
//   sccb_start        single-cycle write request
//   sccb_ready        SCCB master idle
//   busy/done         sequence in progress / sequence finished (level)
module ov7670_config_seq
    import ov7670_cfg_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DELAY_MS = DEFAULT_DELAY_MS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic [7:0]  sccb_addr,
    output logic [7:0]  sccb_data,
    output logic        sccb_start,
    input  logic        sccb_ready,
    output logic        busy,
    output logic        done
);

    localparam int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;
    localparam int CNT_W        = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

    cfg_state_e       state_q, state_d;
    logic [7:0]       rom_addr_q, rom_addr_d;
    logic [7:0]       sccb_addr_q, sccb_addr_d;
    logic [7:0]       sccb_data_q, sccb_data_d;
    logic             sccb_start_q, sccb_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Set for the first WAIT_SCCB cycle: the master still shows ready
    // while it is sampling our start pulse.
    logic             skip_q, skip_d;

    logic advance;
    logic go_done;

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        sccb_addr_d  = sccb_addr_q;
        sccb_data_d  = sccb_data_q;
        sccb_start_d = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        cnt_d        = cnt_q;
        skip_d       = skip_q;
        advance      = 1'b0;
        go_done      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    rom_addr_d = 8'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (rom_dout == CFG_DELAY) begin
                    state_d = S_DELAY;
                    cnt_d   = '0;
                end else if (rom_dout[15:8] == CFG_MARK_HI) begin
                    go_done = 1'b1;
                end else begin
                    sccb_addr_d = rom_dout[15:8];
                    sccb_data_d = rom_dout[7:0];
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (sccb_ready) begin
                    sccb_start_d = 1'b1;
                    skip_d       = 1'b1;
                    state_d      = S_WAIT_SCCB;
                end
            end
            S_WAIT_SCCB: begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (sccb_ready) begin
                    advance = 1'b1;
                end
            end
            S_DELAY: begin
                if (cnt_q == CNT_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Address 255 is the last ROM slot; finish there instead of wrapping.
        if (advance) begin
            if (rom_addr_q == 8'hFF) begin
                go_done = 1'b1;
            end else begin
                rom_addr_d = rom_addr_q + 8'd1;
                state_d    = S_FETCH;
            end
        end

        if (go_done) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= 8'd0;
            sccb_addr_q  <= 8'd0;
            sccb_data_q  <= 8'd0;
            sccb_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            skip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            sccb_addr_q  <= sccb_addr_d;
            sccb_data_q  <= sccb_data_d;
            sccb_start_q <= sccb_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            skip_q       <= skip_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign sccb_addr  = sccb_addr_q;
    assign sccb_data  = sccb_data_q;
    assign sccb_start = sccb_start_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// tb/tb_ov7670_config_seq.sv - directed self-checking bench for ov7670_config_seq
module tb_ov7670_config_seq;

    localparam int CLK_FREQ = 1000;
    localparam int DELAY_MS = 5;
    localparam int DC       = CLK_FREQ / 1000 * DELAY_MS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic [7:0]  sccb_addr;
    logic [7:0]  sccb_data;
    logic        sccb_start;
    logic        sccb_ready;
    logic        busy;
    logic        done;

    ov7670_config_seq #(
        .CLK_FREQ (CLK_FREQ),
        .DELAY_MS (DELAY_MS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .sccb_addr  (sccb_addr),
        .sccb_data  (sccb_data),
        .sccb_start (sccb_start),
        .sccb_ready (sccb_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // ROM model: 0 = full table, 1 = delay stub, 2 = constant 0x0101
    int rom_mode = 0;

    function automatic logic [15:0] rom_lookup(input logic [7:0] a);
        logic [15:0] v;
        case (rom_mode)
            0: begin
                if (a == 8'd0)       v = 16'h1280;
                else if (a == 8'd1)  v = 16'hFFF0;
                else if (a == 8'd2)  v = 16'h1214;
                else if (a == 8'd73) v = 16'h13E7;
                else if (a >= 8'd74) v = 16'hFFFF;
                else                 v = {a, 8'h5A};
            end
            1: begin
                if (a == 8'd0)      v = 16'h1280;
                else if (a == 8'd1) v = 16'hFFF0;
                else                v = 16'hFFFF;
            end
            default: v = 16'h0101;
        endcase
        return v;
    endfunction

    always @(posedge clk) rom_dout <= rom_lookup(rom_addr);

    // SCCB master model: ready drops after accepting start, returns a few cycles later
    logic mdl_ready;
    int   mdl_cnt;
    logic hold_ready = 1'b0;
    assign sccb_ready = mdl_ready & ~hold_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_ready <= 1'b1;
            mdl_cnt   <= 0;
        end else if (sccb_start && sccb_ready) begin
            mdl_ready <= 1'b0;
            mdl_cnt   <= 3;
        end else if (!mdl_ready) begin
            if (mdl_cnt == 1) mdl_ready <= 1'b1;
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] wr_q[$];
    int          wr_cyc[$];
    int          rise_q[$];
    int          fetch2_cyc = -1;
    int          bad_start  = 0;
    logic        prev_ready = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            if (sccb_start) begin
                wr_q.push_back({sccb_addr, sccb_data});
                wr_cyc.push_back(cyc);
                if (hold_ready) bad_start++;
            end
            if (sccb_ready && !prev_ready) rise_q.push_back(cyc);
            if (rom_addr == 8'd2 && fetch2_cyc < 0) fetch2_cyc = cyc;
        end
        prev_ready = sccb_ready;
    end

    task automatic clear_log();
        wr_q.delete();
        wr_cyc.delete();
        rise_q.delete();
        fetch2_cyc = -1;
        bad_start  = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        check(tag, done, 1'b1);
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && wr_q.size() < n; i++) @(negedge clk);
        check(tag, wr_q.size() >= n, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check({tag, "_addr"},  rom_addr, 8'd0);
        check({tag, "_start"}, sccb_start, 1'b0);
        check({tag, "_saddr"}, sccb_addr, 8'd0);
        check({tag, "_sdata"}, sccb_data, 8'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Full table, with an ignored start mid-sequence
        rom_mode = 0;
        clear_log();
        pulse_start();
        wait_writes("full_w10", 10, 2000);
        pulse_start();
        wait_done("full_done_timeout", 5000);
        check("full_count", wr_q.size(), 73);
        check("full_first", wr_q[0], 16'h1280);
        check("full_second", wr_q[1], 16'h1214);
        check("full_last", wr_q[wr_q.size()-1], 16'h13E7);
        check("full_busy", busy, 1'b0);
        check("full_rom_addr", rom_addr, 8'd74);
        check("full_delay_gap", (wr_cyc[1] - wr_cyc[0]) >= (wr_cyc[2] - wr_cyc[1]) + DC, 1'b1);

        // Restart from DONE
        repeat (3) @(negedge clk);
        clear_log();
        pulse_start();
        check("restart_done", done, 1'b0);
        check("restart_busy", busy, 1'b1);
        check("restart_addr", rom_addr, 8'd0);
        wait_done("restart_done_timeout", 5000);
        check("restart_count", wr_q.size(), 73);
        check("restart_rom_addr", rom_addr, 8'd74);

        // Delay marker stub
        rom_mode = 1;
        clear_log();
        pulse_start();
        wait_done("dly_done_timeout", 500);
        check("dly_count", wr_q.size(), 1);
        check("dly_rom_addr", rom_addr, 8'd2);
        check("dly_rise_seen", rise_q.size() >= 1, 1'b1);
        check("dly_gap", (fetch2_cyc - rise_q[0]) >= DC, 1'b1);

        // Back-pressure before the first write
        clear_log();
        hold_ready = 1'b1;
        pulse_start();
        repeat (20) @(negedge clk);
        check("bp_no_start", wr_q.size(), 0);
        check("bp_hold_addr", {sccb_addr, sccb_data}, 16'h1280);
        hold_ready = 1'b0;
        wait_done("bp_done_timeout", 500);
        check("bp_count", wr_q.size(), 1);
        check("bp_data", wr_q[0], 16'h1280);
        check("bp_bad_start", bad_start, 0);

        // No end marker: must stop at address 255
        rom_mode = 2;
        clear_log();
        pulse_start();
        wait_done("noend_done_timeout", 6000);
        check("noend_count", wr_q.size(), 256);
        check("noend_rom_addr", rom_addr, 8'd255);
        repeat (10) @(negedge clk);
        check("noend_no_wrap", rom_addr, 8'd255);
        check("noend_busy", busy, 1'b0);

        // Async reset inside DELAY
        rom_mode = 0;
        clear_log();
        pulse_start();
        wait_writes("rst_dly_w1", 1, 200);
        repeat (9) @(negedge clk);
        check("rst_dly_pre_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_dly");
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_dly_quiet", wr_q.size(), 1);
        check("rst_dly_idle", busy, 1'b0);

        // Async reset inside WAIT_SCCB
        clear_log();
        pulse_start();
        wait_writes("rst_wait_w1", 1, 200);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_wait");
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_wait_quiet", wr_q.size(), 1);
        check("rst_wait_idle", busy, 1'b0);
        check("rst_wait_done", done, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
